// File: rtl/xgmii_tx_encoder_if.sv
// Frame-beat stream from the MAC frame generator into xgmii_tx_encoder.
// The i_err sideband exists only when XGMII_ERR_INPUT_EN is defined.
interface xgmii_tx_encoder_if;
    logic        i_valid;
    logic [63:0] i_data;
    logic        i_last;
    logic [2:0]  i_last_bytes;
`ifdef XGMII_ERR_INPUT_EN
    logic        i_err;
`endif
    logic        o_ready;

`ifdef XGMII_ERR_INPUT_EN
    modport master (output i_valid, i_data, i_last, i_last_bytes, i_err, input o_ready);
    modport slave  (input i_valid, i_data, i_last, i_last_bytes, i_err, output o_ready);
`else
    modport master (output i_valid, i_data, i_last, i_last_bytes, input o_ready);
    modport slave  (input i_valid, i_data, i_last, i_last_bytes, output o_ready);
`endif
endinterface

// File: rtl/xgmii_tx_encoder.sv
// XGMII transmit encoder: /S/, /T/, /I/ insertion, inter-frame gap and underrun abort.
// Optional feature macro XGMII_ERR_INPUT_EN adds an i_err input that aborts a frame.
module xgmii_tx_encoder #(
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic               clk,
    input  logic               i_rst_n,
    xgmii_tx_encoder_if.slave  bus,
    output logic [63:0]        o_txd,
    output logic [7:0]         o_txc,
    output logic [15:0]        o_frame_cnt
);
    localparam logic [7:0]  CH_S      = 8'hFB;
    localparam logic [7:0]  CH_T      = 8'hFD;
    localparam logic [7:0]  CH_I      = 8'h07;
    localparam logic [63:0] IDLE_WORD = {8{8'h07}};
    localparam logic [63:0] ERR_WORD  = {8{8'hFE}};
    localparam logic [63:0] TERM_WORD = {{7{8'h07}}, 8'hFD};

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_TERM, S_IFG, S_ABORT} state_t;

    // Idle words still owed after ctrl_bytes control characters already went out.
    function automatic logic [3:0] gap_words(input int unsigned ctrl_bytes);
        if (IFG_BYTES <= ctrl_bytes) return 4'd0;
        return 4'((IFG_BYTES - ctrl_bytes + 7) / 8);
    endfunction

    localparam logic [3:0] TERM_GAP  = gap_words(8);
    localparam logic [3:0] ABORT_GAP = gap_words(0);

    state_t      state_q, state_d;
    logic [3:0]  ifg_q, ifg_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic        ready_q, ready_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        accept;
    logic [3:0]  n_bytes;
    logic [63:0] term_txd;
    logic [7:0]  term_txc;
    logic        final_beat;
    logic        enter_gap;
    logic [3:0]  gap_d;

    assign accept  = bus.i_valid && ready_q;
    assign n_bytes = (bus.i_last_bytes == 3'd0) ? 4'd8 : {1'b0, bus.i_last_bytes};

    // Final-beat word: data below lane N, /T/ at lane N, /I/ above it.
    always_comb begin
        term_txd = bus.i_data;
        term_txc = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (k == int'(n_bytes)) begin
                term_txd[8*k +: 8] = CH_T;
                term_txc[k]        = 1'b1;
            end else if (k > int'(n_bytes)) begin
                term_txd[8*k +: 8] = CH_I;
                term_txc[k]        = 1'b1;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        ifg_d       = ifg_q;
        txd_d       = IDLE_WORD;
        txc_d       = 8'hFF;
        frame_cnt_d = frame_cnt_q;
        final_beat  = 1'b0;
        enter_gap   = 1'b0;
        gap_d       = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.i_last) begin
                        txd_d      = {term_txd[63:8], CH_S};
                        txc_d      = term_txc | 8'h01;
                        final_beat = 1'b1;
                    end else begin
                        txd_d   = {bus.i_data[63:8], CH_S};
                        txc_d   = 8'h01;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!bus.i_valid) begin
                    txd_d   = ERR_WORD;
                    state_d = S_ABORT;
                end
`ifdef XGMII_ERR_INPUT_EN
                else if (bus.i_err) begin
                    txd_d = ERR_WORD;
                    if (bus.i_last) begin
                        enter_gap = 1'b1;
                        gap_d     = ABORT_GAP;
                    end else begin
                        state_d = S_ABORT;
                    end
                end
`endif
                else if (!bus.i_last) begin
                    txd_d = bus.i_data;
                    txc_d = 8'h00;
                end else begin
                    txd_d      = term_txd;
                    txc_d      = term_txc;
                    final_beat = 1'b1;
                end
            end
            S_TERM: begin
                txd_d       = TERM_WORD;
                frame_cnt_d = frame_cnt_q + 16'd1;
                enter_gap   = 1'b1;
                gap_d       = TERM_GAP;
            end
            S_IFG: begin
                if (ifg_q <= 4'd1) state_d = S_IDLE;
                else               ifg_d   = ifg_q - 4'd1;
            end
            S_ABORT: begin
                if (accept && bus.i_last) begin
                    enter_gap = 1'b1;
                    gap_d     = ABORT_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A full 8-byte final beat has no room for /T/, so it is deferred to S_TERM.
        if (final_beat) begin
            if (n_bytes == 4'd8) begin
                state_d = S_TERM;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                enter_gap   = 1'b1;
                gap_d       = gap_words(32'(4'd8 - n_bytes));
            end
        end

        if (enter_gap) begin
            state_d = (gap_d == 4'd0) ? S_IDLE : S_IFG;
            ifg_d   = gap_d;
        end

        ready_d = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_ABORT);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            ifg_q       <= 4'd0;
            txd_q       <= IDLE_WORD;
            txc_q       <= 8'hFF;
            ready_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            ifg_q       <= ifg_d;
            txd_q       <= txd_d;
            txc_q       <= txc_d;
            ready_q     <= ready_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.o_ready = ready_q;
    assign o_txd       = txd_q;
    assign o_txc       = txc_q;
    assign o_frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_xgmii_tx_encoder.sv
// Directed self-checking bench for xgmii_tx_encoder with IFG_BYTES = 12.
module tb_xgmii_tx_encoder;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] PRE    = 64'hD555555555555555;
    localparam logic [63:0] PRE_S  = 64'hD5555555555555FB;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [63:0] o_txd;
    logic [7:0]  o_txc;
    logic [15:0] o_frame_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    xgmii_tx_encoder_if bus ();

    xgmii_tx_encoder #(.IFG_BYTES(12)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .bus         (bus),
        .o_txd       (o_txd),
        .o_txc       (o_txc),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [63:0] txd,
                               input logic [7:0] txc, input logic rdy);
        check({tag, ".txd"}, o_txd, txd);
        check({tag, ".txc"}, {56'd0, o_txc}, {56'd0, txc});
        check({tag, ".rdy"}, {63'd0, bus.o_ready}, {63'd0, rdy});
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] exp);
        check(tag, {48'd0, o_frame_cnt}, {48'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic last, input logic [2:0] lb);
        bus.i_valid      = v;
        bus.i_data       = d;
        bus.i_last       = last;
        bus.i_last_bytes = lb;
`ifdef XGMII_ERR_INPUT_EN
        bus.i_err        = 1'b0;
`endif
    endtask

    task automatic short_frame();
        drive(1'b1, PRE, 1'b0, 3'd0);
        tick();
        drive(1'b1, 64'h00000000AABBCCDD, 1'b1, 3'd4);
        tick();
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        tick();
    endtask

    initial begin
        i_rst_n = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        #12;
        expect_word("rst", IDLE_W, 8'hFF, 1'b0);
        check_cnt("rst.cnt", 16'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_word("idle", IDLE_W, 8'hFF, 1'b1);
        end
        check_cnt("idle.cnt", 16'd0);

        // Three-beat frame ending with 4 valid bytes.
        drive(1'b1, PRE, 1'b0, 3'd0);
        tick();
        expect_word("a.w1", PRE_S, 8'h01, 1'b1);
        drive(1'b1, 64'h1122334455667788, 1'b0, 3'd0);
        tick();
        expect_word("a.w2", 64'h1122334455667788, 8'h00, 1'b1);
        drive(1'b1, 64'h00000000AABBCCDD, 1'b1, 3'd4);
        tick();
        expect_word("a.w3", 64'h070707FDAABBCCDD, 8'hF0, 1'b0);
        check_cnt("a.cnt", 16'd1);
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        tick();
        expect_word("a.ifg", IDLE_W, 8'hFF, 1'b1);

        // Full 8-byte final beat forces a separate /T/ word.
        drive(1'b1, PRE, 1'b0, 3'd0);
        tick();
        expect_word("b.w1", PRE_S, 8'h01, 1'b1);
        drive(1'b1, 64'h0123456789ABCDEF, 1'b1, 3'd0);
        tick();
        expect_word("b.w2", 64'h0123456789ABCDEF, 8'h00, 1'b0);
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        tick();
        expect_word("b.term", 64'h07070707070707FD, 8'hFF, 1'b0);
        check_cnt("b.cnt", 16'd2);
        tick();
        expect_word("b.ifg", IDLE_W, 8'hFF, 1'b1);

        // Seven valid bytes: /T/ in lane 7, two idle words, next frame held waiting.
        drive(1'b1, PRE, 1'b0, 3'd0);
        tick();
        expect_word("c.w1", PRE_S, 8'h01, 1'b1);
        drive(1'b1, 64'h0099887766554433, 1'b1, 3'd7);
        tick();
        expect_word("c.w2", 64'hFD99887766554433, 8'h80, 1'b0);
        check_cnt("c.cnt", 16'd3);
        drive(1'b1, PRE, 1'b0, 3'd0);
        tick();
        expect_word("c.ifg1", IDLE_W, 8'hFF, 1'b0);
        tick();
        expect_word("c.ifg2", IDLE_W, 8'hFF, 1'b1);
        tick();
        expect_word("d.w1", PRE_S, 8'h01, 1'b1);

        // Underrun: /E/ word, beats discarded to i_last, then two idle words.
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        tick();
        expect_word("d.err", ERR_W, 8'hFF, 1'b1);
        drive(1'b1, 64'h1111111111111111, 1'b0, 3'd0);
        tick();
        expect_word("d.drop1", IDLE_W, 8'hFF, 1'b1);
        drive(1'b1, 64'h2222222222222222, 1'b1, 3'd3);
        tick();
        expect_word("d.drop2", IDLE_W, 8'hFF, 1'b0);
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        tick();
        expect_word("d.ifg1", IDLE_W, 8'hFF, 1'b0);
        tick();
        expect_word("d.ifg2", IDLE_W, 8'hFF, 1'b1);
        check_cnt("d.cnt", 16'd3);

        // Counter wrap: jump close to the top instead of sending 65k frames.
        force dut.frame_cnt_q = 16'hFFFE;
        #1;
        release dut.frame_cnt_q;
        short_frame();
        check_cnt("wrap.ffff", 16'hFFFF);
        short_frame();
        check_cnt("wrap.zero", 16'h0000);

        // Asynchronous reset mid-frame.
        drive(1'b1, PRE, 1'b0, 3'd0);
        tick();
        expect_word("r.w1", PRE_S, 8'h01, 1'b1);
        drive(1'b1, 64'h3333333333333333, 1'b0, 3'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        expect_word("r.async", IDLE_W, 8'hFF, 1'b0);
        check_cnt("r.cnt", 16'd0);
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        tick();
        expect_word("r.after", IDLE_W, 8'hFF, 1'b1);
        tick();
        expect_word("r.after2", IDLE_W, 8'hFF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
